// File: rtl/tlb_array_if.sv
// tlb_if: TLB write/read/lookup port bundle between writeback/CP0 (master) and tlb_array (slave).
// With TLB_INV_ALL_EN defined an inv_all strobe is carried as well.
interface tlb_if #(parameter int TLBNUM = 16);
  localparam int IW = $clog2(TLBNUM);
  logic [18:0]   s0_vpn2;
  logic          s0_odd_page;
  logic [7:0]    s0_asid;
  logic          s0_found;
  logic [IW-1:0] s0_index;
  logic [19:0]   s0_pfn;
  logic [2:0]    s0_c;
  logic          s0_d;
  logic          s0_v;
  logic [18:0]   s1_vpn2;
  logic          s1_odd_page;
  logic [7:0]    s1_asid;
  logic          s1_found;
  logic [IW-1:0] s1_index;
  logic [19:0]   s1_pfn;
  logic [2:0]    s1_c;
  logic          s1_d;
  logic          s1_v;
  logic          we;
  logic [IW-1:0] w_index;
  logic [18:0]   w_vpn2;
  logic [7:0]    w_asid;
  logic          w_g;
  logic [19:0]   w_pfn0;
  logic [2:0]    w_c0;
  logic          w_d0;
  logic          w_v0;
  logic [19:0]   w_pfn1;
  logic [2:0]    w_c1;
  logic          w_d1;
  logic          w_v1;
  logic [IW-1:0] r_index;
  logic [18:0]   r_vpn2;
  logic [7:0]    r_asid;
  logic          r_g;
  logic [19:0]   r_pfn0;
  logic [2:0]    r_c0;
  logic          r_d0;
  logic          r_v0;
  logic [19:0]   r_pfn1;
  logic [2:0]    r_c1;
  logic          r_d1;
  logic          r_v1;
`ifdef TLB_INV_ALL_EN
  logic          inv_all;
`endif
  modport master (
    output s0_vpn2, s0_odd_page, s0_asid, s1_vpn2, s1_odd_page, s1_asid,
           we, w_index, w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1,
           r_index,
`ifdef TLB_INV_ALL_EN
           inv_all,
`endif
    input  s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
           s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
           r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1
  );
  modport slave (
    input  s0_vpn2, s0_odd_page, s0_asid, s1_vpn2, s1_odd_page, s1_asid,
           we, w_index, w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1,
           r_index,
`ifdef TLB_INV_ALL_EN
           inv_all,
`endif
    output s0_found, s0_index, s0_pfn, s0_c, s0_d, s0_v,
           s1_found, s1_index, s1_pfn, s1_c, s1_d, s1_v,
           r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1
  );
endinterface

// File: rtl/tlb_array.sv
// tlb_array: 16-entry fully associative MIPS32 JTLB, one write, one read, two lookup ports.
// Optional TLB_INV_ALL_EN adds inv_all, clearing every existence bit (and dropping a same-cycle write).
module tlb_array #(parameter int TLBNUM = 16) (
  input logic   clk,
  input logic   resetn,
  tlb_if.slave  t
);
  localparam int IW = $clog2(TLBNUM);
  logic [18:0]       vpn2_q [TLBNUM];
  logic [7:0]        asid_q [TLBNUM];
  logic [TLBNUM-1:0] g_q;
  logic [TLBNUM-1:0] e_q;
  // page records packed as {pfn, c, d, v}
  logic [24:0]       p0_q [TLBNUM];
  logic [24:0]       p1_q [TLBNUM];
  logic [TLBNUM-1:0] m0, m1;
  logic [IW-1:0]     idx0, idx1;
  logic [24:0]       pg0, pg1;
  logic              wr_en;
`ifdef TLB_INV_ALL_EN
  assign wr_en = t.we && !t.inv_all;
`else
  assign wr_en = t.we;
`endif
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      for (int i = 0; i < TLBNUM; i++) begin
        vpn2_q[i] <= '0;
        asid_q[i] <= '0;
        p0_q[i]   <= '0;
        p1_q[i]   <= '0;
      end
      g_q <= '0;
      e_q <= '0;
    end else begin
`ifdef TLB_INV_ALL_EN
      if (t.inv_all) e_q <= '0;
`endif
      if (wr_en) begin
        vpn2_q[t.w_index] <= t.w_vpn2;
        asid_q[t.w_index] <= t.w_asid;
        g_q[t.w_index]    <= t.w_g;
        e_q[t.w_index]    <= 1'b1;
        p0_q[t.w_index]   <= {t.w_pfn0, t.w_c0, t.w_d0, t.w_v0};
        p1_q[t.w_index]   <= {t.w_pfn1, t.w_c1, t.w_d1, t.w_v1};
      end
    end
  always_comb
    for (int i = 0; i < TLBNUM; i++) begin
      m0[i] = e_q[i] && vpn2_q[i] == t.s0_vpn2 && (g_q[i] || asid_q[i] == t.s0_asid);
      m1[i] = e_q[i] && vpn2_q[i] == t.s1_vpn2 && (g_q[i] || asid_q[i] == t.s1_asid);
    end
  // descending scan so the lowest matching index is the one left standing
  always_comb begin
    idx0 = '0;
    idx1 = '0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (m0[i]) idx0 = IW'(i);
      if (m1[i]) idx1 = IW'(i);
    end
  end
  assign pg0 = !(|m0) ? '0 : t.s0_odd_page ? p1_q[idx0] : p0_q[idx0];
  assign pg1 = !(|m1) ? '0 : t.s1_odd_page ? p1_q[idx1] : p0_q[idx1];
  assign t.s0_found = |m0;
  assign t.s0_index = idx0;
  assign {t.s0_pfn, t.s0_c, t.s0_d, t.s0_v} = pg0;
  assign t.s1_found = |m1;
  assign t.s1_index = idx1;
  assign {t.s1_pfn, t.s1_c, t.s1_d, t.s1_v} = pg1;
  assign t.r_vpn2 = vpn2_q[t.r_index];
  assign t.r_asid = asid_q[t.r_index];
  assign t.r_g    = g_q[t.r_index];
  assign {t.r_pfn0, t.r_c0, t.r_d0, t.r_v0} = p0_q[t.r_index];
  assign {t.r_pfn1, t.r_c1, t.r_d1, t.r_v1} = p1_q[t.r_index];
endmodule

// File: tb/tb_tlb_array.sv
// tb_tlb_array: directed vectors with hand-computed expectations for tlb_array.
module tb_tlb_array;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int n_vec = 0;
  int n_err = 0;
  tlb_if #(.TLBNUM(16)) bus ();
  tlb_array #(.TLBNUM(16)) dut (.clk(clk), .resetn(resetn), .t(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic look(input logic [18:0] v, input logic [7:0] a, input logic o);
    bus.s0_vpn2 = v; bus.s0_asid = a; bus.s0_odd_page = o;
    bus.s1_vpn2 = v; bus.s1_asid = a; bus.s1_odd_page = o;
    #1;
  endtask
  task automatic setw(input logic [3:0] idx, input logic [18:0] vpn2, input logic [7:0] asid,
                      input logic g, input logic [19:0] pfn0, input logic [2:0] c0, input logic d0,
                      input logic v0, input logic [19:0] pfn1, input logic [2:0] c1, input logic d1,
                      input logic v1);
    bus.w_index = idx; bus.w_vpn2 = vpn2; bus.w_asid = asid; bus.w_g = g;
    bus.w_pfn0 = pfn0; bus.w_c0 = c0; bus.w_d0 = d0; bus.w_v0 = v0;
    bus.w_pfn1 = pfn1; bus.w_c1 = c1; bus.w_d1 = d1; bus.w_v1 = v1;
  endtask
  task automatic wr(input logic [3:0] idx, input logic [18:0] vpn2, input logic [7:0] asid,
                    input logic g, input logic [19:0] pfn0, input logic [19:0] pfn1);
    setw(idx, vpn2, asid, g, pfn0, 3'd3, 1'b1, 1'b1, pfn1, 3'd2, 1'b0, 1'b1);
    bus.we = 1'b1;
    tick();
    bus.we = 1'b0;
  endtask
  function automatic logic [31:0] rd_all();
    return 32'(bus.r_vpn2) | 32'(bus.r_asid) | 32'(bus.r_g) | 32'(bus.r_pfn0) | 32'(bus.r_c0)
         | 32'(bus.r_d0) | 32'(bus.r_v0) | 32'(bus.r_pfn1) | 32'(bus.r_c1) | 32'(bus.r_d1) | 32'(bus.r_v1);
  endfunction
  initial begin
    bus.we = 1'b0;
    bus.r_index = '0;
`ifdef TLB_INV_ALL_EN
    bus.inv_all = 1'b0;
`endif
    setw(4'd0, '0, '0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    look('0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;
    // reset state
    look(19'h00000, 8'h00, 1'b0);
    chk("rst_found", 32'(bus.s0_found), 32'd0);
    chk("rst_index", 32'(bus.s0_index), 32'd0);
    chk("rst_pfn", 32'(bus.s0_pfn), 32'd0);
    bus.r_index = 4'd5; #1;
    chk("rst_read5", rd_all(), 32'd0);
    // basic write / odd+even page / asid mismatch
    setw(4'd3, 19'h12345, 8'h1A, 1'b0, 20'h00ABC, 3'd3, 1'b1, 1'b1, 20'h00DEF, 3'd2, 1'b0, 1'b1);
    bus.we = 1'b1; tick(); bus.we = 1'b0;
    look(19'h12345, 8'h1A, 1'b1);
    chk("odd_found", 32'(bus.s1_found), 32'd1);
    chk("odd_index", 32'(bus.s1_index), 32'd3);
    chk("odd_pfn", 32'(bus.s1_pfn), 32'h00DEF);
    chk("odd_cdv", {29'd0, bus.s1_c} << 2 | 32'({bus.s1_d, bus.s1_v}), 32'b1001);
    look(19'h12345, 8'h1A, 1'b0);
    chk("even_pfn", 32'(bus.s1_pfn), 32'h00ABC);
    chk("even_cdv", {29'd0, bus.s1_c} << 2 | 32'({bus.s1_d, bus.s1_v}), 32'b1111);
    look(19'h12345, 8'h1B, 1'b1);
    chk("asid_miss", 32'(bus.s1_found), 32'd0);
    chk("miss_pfn_zero", 32'(bus.s1_pfn), 32'd0);
    chk("miss_v_zero", 32'(bus.s1_v), 32'd0);
    // global entry ignores asid
    wr(4'd7, 19'h00400, 8'h05, 1'b1, 20'h11111, 20'h22222);
    look(19'h00400, 8'hFF, 1'b0);
    chk("g_found", 32'(bus.s0_found), 32'd1);
    chk("g_index", 32'(bus.s0_index), 32'd7);
    chk("g_pfn", 32'(bus.s0_pfn), 32'h11111);
    chk("g_s1_index", 32'(bus.s1_index), 32'd7);
    bus.r_index = 4'd7; #1;
    chk("rd7_g", 32'(bus.r_g), 32'd1);
    chk("rd7_asid", 32'(bus.r_asid), 32'h05);
    chk("rd7_pfn1", 32'(bus.r_pfn1), 32'h22222);
    bus.r_index = 4'd15; #1;
    chk("rd15_zero", rd_all(), 32'd0);
    // same-cycle write is not visible until after the edge
    setw(4'd2, 19'h7FFFF, 8'h00, 1'b0, 20'h33333, 3'd1, 1'b0, 1'b1, 20'h44444, 3'd0, 1'b0, 1'b0);
    bus.we = 1'b1;
    bus.r_index = 4'd2;
    look(19'h7FFFF, 8'h00, 1'b0);
    chk("wbyp_found0", 32'(bus.s0_found), 32'd0);
    chk("wbyp_rd0", 32'(bus.r_vpn2), 32'd0);
    tick(); bus.we = 1'b0; #1;
    chk("wbyp_found1", 32'(bus.s0_found), 32'd1);
    chk("wbyp_index", 32'(bus.s0_index), 32'd2);
    chk("wbyp_rd1", 32'(bus.r_vpn2), 32'h7FFFF);
    // duplicates: lowest index wins; overwrite in place
    wr(4'd9, 19'h0ABCD, 8'h10, 1'b0, 20'h99999, 20'h0);
    wr(4'd4, 19'h0ABCD, 8'h10, 1'b0, 20'h44444, 20'h0);
    look(19'h0ABCD, 8'h10, 1'b0);
    chk("dup_index", 32'(bus.s0_index), 32'd4);
    chk("dup_pfn", 32'(bus.s0_pfn), 32'h44444);
    wr(4'd4, 19'h0ABCE, 8'h10, 1'b0, 20'h55555, 20'h0);
    look(19'h0ABCD, 8'h10, 1'b0);
    chk("ovw_index", 32'(bus.s1_index), 32'd9);
    chk("ovw_pfn", 32'(bus.s1_pfn), 32'h99999);
    look(19'h0ABCE, 8'h10, 1'b0);
    chk("ovw_new_index", 32'(bus.s0_index), 32'd4);
`ifdef TLB_INV_ALL_EN
    for (int i = 0; i < 16; i++) wr(4'(i), 19'h00100 + 19'(i), 8'h00, 1'b0, 20'(i), 20'h0);
    look(19'h0010F, 8'h00, 1'b0);
    chk("pop_index15", 32'(bus.s0_index), 32'd15);
    setw(4'd1, 19'h55555, 8'h00, 1'b1, 20'hAAAAA, 3'd0, 1'b0, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
    bus.we = 1'b1; bus.inv_all = 1'b1;
    tick();
    bus.we = 1'b0; bus.inv_all = 1'b0;
    for (int i = 0; i < 16; i++) begin
      look(19'h00100 + 19'(i), 8'h00, 1'b0);
      chk("inv_miss", 32'(bus.s0_found), 32'd0);
    end
    look(19'h55555, 8'h00, 1'b0);
    chk("inv_wdrop_miss", 32'(bus.s0_found), 32'd0);
    bus.r_index = 4'd1; #1;
    chk("inv_rd_vpn2", 32'(bus.r_vpn2), 32'h00101);
    chk("inv_rd_pfn0", 32'(bus.r_pfn0), 32'd1);
`endif
    // asynchronous reset mid-operation drops a pending write
    wr(4'd3, 19'h12345, 8'h1A, 1'b0, 20'h00ABC, 20'h00DEF);
    setw(4'd5, 19'h06666, 8'h00, 1'b1, 20'h66666, 3'd0, 1'b0, 1'b1, 20'h0, 3'd0, 1'b0, 1'b0);
    bus.we = 1'b1;
    look(19'h12345, 8'h1A, 1'b0);
    chk("pre_rst_found", 32'(bus.s0_found), 32'd1);
    resetn = 1'b0; #1;
    chk("async_rst_miss", 32'(bus.s0_found), 32'd0);
    tick();
    bus.we = 1'b0;
    #2 resetn = 1'b1;
    bus.r_index = 4'd5; #1;
    chk("rst_wdrop_rd5", rd_all(), 32'd0);
    bus.r_index = 4'd3; #1;
    chk("rst_rd3", rd_all(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
